// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF-stage program-counter unit:
// datapath width, reset vector, fetch states and the alignment helper.
package fetch_pc_unit_pkg;

   localparam int XLEN = 32;

   // Default PC loaded on reset
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instructions are word aligned: the two LSBs of a fetch address are zero
   localparam int ALIGN_BITS = 2;

   // Fetch sequencer states (plain constants so legacy code can compare them)
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t S_BOOT  = 2'd0;
   localparam fetch_state_t S_RUN   = 2'd1;
   localparam fetch_state_t S_FLUSH = 2'd2;

   // Clear the alignment bits of an address
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/fetch_pc_unit_flush_counter.sv
// Loadable down-counter used to time a pipeline flush window.
// active = count non-zero, last = count is one (final decrement pending).
module flush_counter #(
   parameter int WIDTH = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             active,
   output logic             last
);

   logic [WIDTH-1:0] cnt;

   // Load on request, otherwise count down to zero and stay there
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RESET)
         cnt <= '0;
      else if (load)
         cnt <= load_value;
      else if (cnt != '0)
         cnt <= cnt - WIDTH'(1);
   end

   assign active = (cnt != '0);
   assign last   = (cnt == WIDTH'(1));

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter: sequences imem fetches, applies branch/jump
// redirects (force-aligned) and drives the IF/ID + ID/EX flush window.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_target_i,
   input  logic            stall_i,
   input  logic            imem_ready_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            fetch_valid_o,
   output logic            flush_o,
   output logic            misaligned_o
);

   localparam int CW = $clog2(FLUSH_CYCLES) + 1;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            running;
   logic            redirect_taken;
   logic            accept;
   logic            flush_active;
   logic            flush_last;

   // Redirects are only honoured once fetching has started (ignored in BOOT)
   assign running        = (state == S_RUN) || (state == S_FLUSH);
   assign redirect_taken = redirect_i && running;
   // Redirect outranks stall, stall outranks imem_ready
   assign accept         = running && imem_ready_i && !stall_i && !redirect_i;

   flush_counter #(
      .WIDTH      (CW)
   ) u_flush_counter (
      .CLK        (CLK),
      .RESET      (RESET),
      .load       (redirect_taken),
      .load_value (CW'(FLUSH_CYCLES - 1)),
      .active     (flush_active),
      .last       (flush_last)
   );

   // PC, fetch state and the registered misaligned-target pulse
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc           <= RESET_PC;
         state        <= S_BOOT;
         misaligned_o <= 1'b0;
      end else begin
         misaligned_o <= redirect_taken && (redirect_target_i[ALIGN_BITS-1:0] != '0);
         case (state)
            S_BOOT: state <= S_RUN;
            S_RUN, S_FLUSH: begin
               if (redirect_taken) begin
                  pc    <= align_pc(redirect_target_i);
                  state <= (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
               end else begin
                  // An advance during FLUSH still happens; its instruction is just not marked valid
                  if (accept)
                     pc <= pc + XLEN'(4);
                  if (state == S_FLUSH && flush_last)
                     state <= S_RUN;
               end
            end
            default: state <= S_BOOT;
         endcase
      end
   end

   assign pc_o          = pc;
   assign imem_addr_o   = pc;
   assign pc_plus4_o    = pc + XLEN'(4);
   assign imem_req_o    = running;
   assign fetch_valid_o = accept && (state == S_RUN);
   // Counter is non-zero exactly while in FLUSH; the redirect cycle itself flushes combinationally
   assign flush_o       = redirect_taken || flush_active;

endmodule
